ifid_hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the IF/ID pipeline register and the PC.
- Detects load-use hazards between the instruction in ID and a load in EX.
- Handles taken-branch redirects resolved in EX.
- Handles instruction-memory wait states.
- Drives the write-enable and flush controls for PC, IF/ID and ID/EX, using a small state machine with cycle counters.

---
 rtl/ifid_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_ifid_hazard_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ifid_hazard_ctrl.sv
// IF/ID hazard controller: load-use stalls, taken-branch flushes and imem wait states.
// Optional macro PERF_CNT_EN builds a saturating counter of PC-stall cycles on stall_cnt.
module ifid_hazard_ctrl #(
  parameter int REG_ADDR_W      = 5,
  parameter int FLUSH_CYCLES    = 2,
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  branch_taken_ex,
  input  logic                  imem_ready,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int LU_W = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES) : 1;
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, LOAD_USE, FLUSH, IMISS} state_t;

  state_t          state, state_nxt;
  logic [LU_W-1:0] lu_left, lu_nxt;
  logic [FL_W-1:0] flush_left, flush_nxt;
  logic            hazard;
  logic            pc_c, we_c, flush_c, bubble_c;

  assign hazard = ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      lu_left    <= '0;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      lu_left    <= lu_nxt;
      flush_left <= flush_nxt;
    end
  end

  // A taken branch overrides every state; RUN and IMISS share the same decision logic.
  always_comb begin
    state_nxt = state;
    lu_nxt    = lu_left;
    flush_nxt = flush_left;
    pc_c      = 1'b1;
    we_c      = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;
    if (branch_taken_ex) begin
      flush_c   = 1'b1;
      bubble_c  = 1'b1;
      flush_nxt = FL_W'(FLUSH_CYCLES - 1);
      lu_nxt    = '0;
      state_nxt = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
    end else begin
      case (state)
        LOAD_USE: begin
          pc_c     = 1'b0;
          we_c     = 1'b0;
          bubble_c = 1'b1;
          if (lu_left <= LU_W'(1)) begin
            lu_nxt    = '0;
            state_nxt = RUN;
          end else begin
            lu_nxt = lu_left - LU_W'(1);
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          pc_c    = imem_ready;
          if (flush_left <= FL_W'(1)) begin
            flush_nxt = '0;
            state_nxt = RUN;
          end else begin
            flush_nxt = flush_left - FL_W'(1);
          end
        end
        default: begin
          if (hazard) begin
            pc_c      = 1'b0;
            we_c      = 1'b0;
            bubble_c  = 1'b1;
            lu_nxt    = LU_W'(LU_STALL_CYCLES - 1);
            state_nxt = (LU_STALL_CYCLES == 1) ? RUN : LOAD_USE;
          end else if (!imem_ready) begin
            pc_c      = 1'b0;
            flush_c   = 1'b1;
            state_nxt = IMISS;
          end else begin
            state_nxt = RUN;
          end
        end
      endcase
    end
  end

  assign pc_write_en   = reset & pc_c;
  assign ifid_write_en = reset & we_c;
  assign ifid_flush    = ~reset | flush_c;
  assign idex_bubble   = ~reset | bubble_c;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else if (!pc_write_en && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Directed self-checking bench for ifid_hazard_ctrl (FLUSH_CYCLES=2, LU_STALL_CYCLES=1, CNT_W=4).
module tb_ifid_hazard_ctrl;

  localparam logic [3:0] DEF   = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] BR    = 4'b1111;
  localparam logic [3:0] MISS  = 4'b0110;
  localparam logic [3:0] FLRDY = 4'b1110;
  localparam logic [3:0] RST   = 4'b0011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, branch_taken_ex = 1'b0, imem_ready = 1'b1;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
  logic [3:0] stall_cnt;
  logic [3:0] ctl;
  int         checks = 0;
  int         errors = 0;

  assign ctl = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble};

  always #5 clk = ~clk;

  ifid_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .LU_STALL_CYCLES(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .branch_taken_ex(branch_taken_ex),
    .imem_ready(imem_ready), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
  );

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic apply_stimulus(input logic br, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u2, input logic rdy);
    @(negedge clk);
    branch_taken_ex = br; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; imem_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ctl !== RST) begin errors++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl, RST); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cnt); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_run_defaults();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 1);
      checks++; if (ctl !== DEF) begin errors++; $display("[TB] FAIL run_default[%0d]: got %b want %b", i, ctl, DEF); end
    end
  endtask

  task automatic test_load_use();
    logic [3:0] exp [6];
    exp = '{STALL, DEF, DEF, STALL, DEF, DEF};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: apply_stimulus(0, 1, 5, 5, 0, 0, 1);
        2: apply_stimulus(0, 1, 5, 3, 5, 0, 1);
        3: apply_stimulus(0, 1, 5, 3, 5, 1, 1);
        5: apply_stimulus(0, 1, 0, 0, 0, 1, 1);
        default: apply_stimulus(0, 0, 0, 0, 0, 0, 1);
      endcase
      checks++; if (ctl !== exp[i]) begin errors++; $display("[TB] FAIL load_use[%0d]: got %b want %b", i, ctl, exp[i]); end
    end
  endtask

  task automatic test_branch_flush();
    logic [3:0] exp [9];
    logic       rdy [9];
    logic       br [9];
    exp  = '{BR, FLRDY, DEF, BR, MISS, DEF, BR, BR, FLRDY};
    rdy  = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    br   = '{1, 0, 0, 1, 0, 0, 1, 1, 0};
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(br[i], 0, 0, 0, 0, 0, rdy[i]);
      checks++; if (ctl !== exp[i]) begin errors++; $display("[TB] FAIL branch_flush[%0d]: got %b want %b", i, ctl, exp[i]); end
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    checks++; if (ctl !== DEF) begin errors++; $display("[TB] FAIL branch_flush_end: got %b want %b", ctl, DEF); end
  endtask

  task automatic test_branch_beats_hazard();
    apply_stimulus(1, 1, 7, 7, 0, 0, 1);
    checks++; if (ctl !== BR) begin errors++; $display("[TB] FAIL br_vs_hazard: got %b want %b", ctl, BR); end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    checks++; if (ctl !== FLRDY) begin errors++; $display("[TB] FAIL br_vs_hazard_next: got %b want %b", ctl, FLRDY); end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    checks++; if (ctl !== DEF) begin errors++; $display("[TB] FAIL br_vs_hazard_run: got %b want %b", ctl, DEF); end
  endtask

  task automatic test_imem_miss();
    logic [3:0] exp [9];
    logic       rdy [9];
    logic       br [9];
    exp = '{MISS, MISS, MISS, DEF, DEF, MISS, BR, FLRDY, DEF};
    rdy = '{0, 0, 0, 1, 1, 0, 0, 1, 1};
    br  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(br[i], 0, 0, 0, 0, 0, rdy[i]);
      checks++; if (ctl !== exp[i]) begin errors++; $display("[TB] FAIL imem_miss[%0d]: got %b want %b", i, ctl, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_flush();
    apply_stimulus(1, 0, 0, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    #1;
    checks++; if (ctl !== RST) begin errors++; $display("[TB] FAIL reset_mid_flush: got %b want %b", ctl, RST); end
    reset = 1'b1;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("[TB] FAIL release_after_flush: got %b want %b", ctl, DEF); end
  endtask

  task automatic test_perf_counter();
    logic [3:0] exp_cnt;
`ifdef PERF_CNT_EN
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL perf_reset: got %0d want 0", stall_cnt); end
    #2 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL perf_count[%0d]: got %0d want %0d", i, stall_cnt, exp_cnt); end
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("[TB] FAIL perf_saturate: got %0d want 15", stall_cnt); end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("[TB] FAIL perf_mid_reset_cnt: got %0d want 0", stall_cnt); end
    checks++; if (ctl !== RST) begin errors++; $display("[TB] FAIL perf_mid_reset_ctl: got %b want %b", ctl, RST); end
    imem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if (ctl !== DEF) begin errors++; $display("[TB] FAIL perf_release: got %b want %b", ctl, DEF); end
`else
    exp_cnt = 4'd0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      checks++; if (stall_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL perf_tied[%0d]: got %0d want 0", i, stall_cnt); end
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
`endif
  endtask

  initial begin
    $display("[TB] starting ifid_hazard_ctrl bench");
    test_reset();
    test_run_defaults();
    test_load_use();
    test_branch_flush();
    test_branch_beats_hazard();
    test_imem_miss();
    test_reset_mid_flush();
    test_perf_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
